regfile_wb: RTL and testbench

- 32-entry x 32-bit register file plus write-back scoreboard for the single-issue datapath.
- Write side is a decoded (5-to-32 demux) write port fed by the existing 5-bit rd-select and 32-bit result-select muxes.
- Two combinational read ports with same-cycle write-back bypass.
- A pending-write scoreboard raises stall when an issuing instruction reads a register whose producer has not yet written back.

---
 rtl/regfile_wb_if.sv | 39 +++
 rtl/regfile_wb.sv | 104 ++++++++++
 tb/tb_regfile_wb.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_if.sv
// regfile_wb_if
// Bundles the register-file datapath signals: the write-back port, the two
// read ports with their "use" qualifiers, the scoreboard set port, and the
// stall / scoreboard observation outputs.
//   master : issue/write-back side (drives addresses, data, strobes)
//   slave  : the register file (returns read data, stall, pend_vec)
interface regfile_wb_if #(
    parameter int DW   = 32,
    parameter int AW   = 5,
    parameter int NREG = 32
);
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [DW-1:0]   wr_data;
    logic [AW-1:0]   rd_addr1;
    logic            rd_use1;
    logic [DW-1:0]   rd_data1;
    logic [AW-1:0]   rd_addr2;
    logic            rd_use2;
    logic [DW-1:0]   rd_data2;
    logic            pend_set;
    logic [AW-1:0]   pend_addr;
    logic            stall;
    logic [NREG-1:0] pend_vec;

    modport master (
        output wr_en, wr_addr, wr_data,
        output rd_addr1, rd_use1, rd_addr2, rd_use2,
        output pend_set, pend_addr,
        input  rd_data1, rd_data2, stall, pend_vec
    );

    modport slave (
        input  wr_en, wr_addr, wr_data,
        input  rd_addr1, rd_use1, rd_addr2, rd_use2,
        input  pend_set, pend_addr,
        output rd_data1, rd_data2, stall, pend_vec
    );
endinterface

// File: rtl/regfile_wb.sv
// regfile_wb
// 32 x 32-bit register file with write-back bypass and a pending-write
// scoreboard for a single-issue pipeline.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset; clears registers and scoreboard
//   bus    : regfile_wb_if.slave
//            wr_en/wr_addr/wr_data      write-back port (address 0 is dropped)
//            rd_addrN/rd_useN/rd_dataN  combinational read ports, N = 1,2
//            pend_set/pend_addr         long-latency producer issued this cycle
//            stall                      issue must hold this cycle
//            pend_vec                   registered scoreboard bits
// NREG must equal 2**AW so every address selects a real register.
module regfile_wb #(
    parameter int DW   = 32,
    parameter int AW   = 5,
    parameter int NREG = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    regfile_wb_if.slave  bus
);

    logic [DW-1:0]   regs [NREG];
    logic [NREG-1:0] pend_vec_q;
    logic [NREG-1:0] pend_vec_d;
    logic            wr_valid;
    logic            haz1;
    logic            haz2;

    // Address 0 is hardwired to zero, so a write aimed at it is no write.
    assign wr_valid = bus.wr_en && (bus.wr_addr != '0);

    // Register array. Entry 0 is never written and therefore stays zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_valid) begin
            regs[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Scoreboard next state: the write-back clear is applied first so that a
    // producer issuing to the same register in the same cycle overrides it.
    always_comb begin
        pend_vec_d = pend_vec_q;
        if (wr_valid) begin
            pend_vec_d[bus.wr_addr] = 1'b0;
        end
        if (bus.pend_set && (bus.pend_addr != '0)) begin
            pend_vec_d[bus.pend_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_vec_q <= '0;
        end else begin
            pend_vec_q <= pend_vec_d;
        end
    end

    // Read ports: zero register, then same-cycle write-back bypass, then the
    // array. Outputs are forced to zero while reset is held so the bypass
    // cannot leak write data during reset.
    always_comb begin
        bus.rd_data1 = '0;
        bus.rd_data2 = '0;
        if (rst_n) begin
            if (bus.rd_addr1 == '0) begin
                bus.rd_data1 = '0;
            end else if (bus.wr_en && (bus.wr_addr == bus.rd_addr1)) begin
                bus.rd_data1 = bus.wr_data;
            end else begin
                bus.rd_data1 = regs[bus.rd_addr1];
            end

            if (bus.rd_addr2 == '0) begin
                bus.rd_data2 = '0;
            end else if (bus.wr_en && (bus.wr_addr == bus.rd_addr2)) begin
                bus.rd_data2 = bus.wr_data;
            end else begin
                bus.rd_data2 = regs[bus.rd_addr2];
            end
        end
    end

    // A hazard exists only on a used, non-zero, pending source whose producer
    // is not writing back right now; a same-cycle write is covered by bypass.
    // Only the registered scoreboard is consulted, so this cycle's pend_set
    // affects stall from the next cycle on.
    always_comb begin
        haz1 = bus.rd_use1 && (bus.rd_addr1 != '0) && pend_vec_q[bus.rd_addr1]
               && !(bus.wr_en && (bus.wr_addr == bus.rd_addr1));
        haz2 = bus.rd_use2 && (bus.rd_addr2 != '0) && pend_vec_q[bus.rd_addr2]
               && !(bus.wr_en && (bus.wr_addr == bus.rd_addr2));
    end

    assign bus.stall    = haz1 || haz2;
    assign bus.pend_vec = pend_vec_q;

endmodule

// File: tb/tb_regfile_wb.sv
// tb_regfile_wb
// Directed-vector bench for regfile_wb. Each vector drives the inputs just
// after a rising edge and queues the hand-computed outputs; a monitor on the
// falling edge pops and compares them against the DUT.
module tb_regfile_wb;

    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int NREG = 32;

    typedef struct packed {
        logic          rst_n;
        logic          we;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic [AW-1:0] a1;
        logic          u1;
        logic [AW-1:0] a2;
        logic          u2;
        logic          ps;
        logic [AW-1:0] pa;
    } stim_t;

    typedef struct packed {
        logic [DW-1:0]   d1;
        logic [DW-1:0]   d2;
        logic            st;
        logic [NREG-1:0] pv;
    } exp_t;

    logic clk;
    logic rst_n;

    exp_t exp_q[$];
    int   vec_id_q[$];
    int   vectors_applied;
    int   miscompares;
    int   next_id;

    regfile_wb_if #(.DW(DW), .AW(AW), .NREG(NREG)) bus ();

    regfile_wb #(.DW(DW), .AW(AW), .NREG(NREG)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic stim_t mk(input logic r, input logic we, input int wa,
                                 input logic [DW-1:0] wd, input int a1,
                                 input logic u1, input int a2, input logic u2,
                                 input logic ps, input int pa);
        stim_t s;
        s.rst_n = r;
        s.we    = we;
        s.wa    = AW'(wa);
        s.wd    = wd;
        s.a1    = AW'(a1);
        s.u1    = u1;
        s.a2    = AW'(a2);
        s.u2    = u2;
        s.ps    = ps;
        s.pa    = AW'(pa);
        return s;
    endfunction

    function automatic exp_t ex(input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                                input logic st, input logic [NREG-1:0] pv);
        exp_t e;
        e.d1 = d1;
        e.d2 = d2;
        e.st = st;
        e.pv = pv;
        return e;
    endfunction

    // Drive one vector just after the rising edge and queue its expectation.
    task automatic apply_stimulus(input stim_t s, input exp_t e);
        @(posedge clk);
        #1;
        rst_n         = s.rst_n;
        bus.wr_en     = s.we;
        bus.wr_addr   = s.wa;
        bus.wr_data   = s.wd;
        bus.rd_addr1  = s.a1;
        bus.rd_use1   = s.u1;
        bus.rd_addr2  = s.a2;
        bus.rd_use2   = s.u2;
        bus.pend_set  = s.ps;
        bus.pend_addr = s.pa;
        exp_q.push_back(e);
        vec_id_q.push_back(next_id);
        next_id++;
    endtask

    task automatic check_output(input int id, input exp_t e);
        vectors_applied++;
        if (bus.rd_data1 !== e.d1) begin
            miscompares++;
            $display("[TB] FAIL vec%0d rd_data1: got %h expected %h", id, bus.rd_data1, e.d1);
        end
        if (bus.rd_data2 !== e.d2) begin
            miscompares++;
            $display("[TB] FAIL vec%0d rd_data2: got %h expected %h", id, bus.rd_data2, e.d2);
        end
        if (bus.stall !== e.st) begin
            miscompares++;
            $display("[TB] FAIL vec%0d stall: got %b expected %b", id, bus.stall, e.st);
        end
        if (bus.pend_vec !== e.pv) begin
            miscompares++;
            $display("[TB] FAIL vec%0d pend_vec: got %h expected %h", id, bus.pend_vec, e.pv);
        end
    endtask

    // Monitor: outputs are combinational, so every queued vector is
    // presented by the falling edge that follows its application.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            check_output(vec_id_q.pop_front(), exp_q.pop_front());
        end
    end

    initial begin
        vectors_applied = 0;
        miscompares     = 0;
        next_id         = 0;
        rst_n           = 1'b0;
        bus.wr_en       = 1'b0;
        bus.wr_addr     = '0;
        bus.wr_data     = '0;
        bus.rd_addr1    = '0;
        bus.rd_use1     = 1'b0;
        bus.rd_addr2    = '0;
        bus.rd_use2     = 1'b0;
        bus.pend_set    = 1'b0;
        bus.pend_addr   = '0;

        // In reset: a write strobe must not bypass onto the read ports.
        apply_stimulus(mk(0, 1, 5, 32'hCAFE_0001, 5, 1, 5, 1, 1, 5), ex(0, 0, 0, 0));

        // Write addr 3, then a dropped write to addr 0.
        apply_stimulus(mk(1, 1, 3, 32'h1234_5678, 3, 0, 0, 0, 0, 0), ex(32'h1234_5678, 0, 0, 0));
        apply_stimulus(mk(1, 1, 0, 32'hFFFF_FFFF, 3, 0, 0, 0, 0, 0), ex(32'h1234_5678, 0, 0, 0));
        apply_stimulus(mk(1, 0, 0, 0, 3, 0, 0, 0, 0, 0), ex(32'h1234_5678, 0, 0, 0));

        // Bypass on both ports over an older value.
        apply_stimulus(mk(1, 1, 9, 32'h11, 9, 0, 3, 0, 0, 0), ex(32'h11, 32'h1234_5678, 0, 0));
        apply_stimulus(mk(1, 1, 9, 32'h22, 9, 0, 9, 0, 0, 0), ex(32'h22, 32'h22, 0, 0));
        apply_stimulus(mk(1, 0, 0, 0, 9, 0, 9, 0, 0, 0), ex(32'h22, 32'h22, 0, 0));

        // Hazard lifecycle on register 4.
        apply_stimulus(mk(1, 0, 0, 0, 4, 1, 0, 0, 1, 4), ex(0, 0, 0, 0));
        apply_stimulus(mk(1, 0, 0, 0, 4, 1, 0, 0, 0, 0), ex(0, 0, 1, 32'h10));
        apply_stimulus(mk(1, 0, 0, 0, 4, 0, 0, 0, 0, 0), ex(0, 0, 0, 32'h10));
        apply_stimulus(mk(1, 1, 4, 32'hAB, 4, 1, 0, 0, 0, 0), ex(32'hAB, 0, 0, 32'h10));
        apply_stimulus(mk(1, 0, 0, 0, 4, 1, 0, 0, 0, 0), ex(32'hAB, 0, 0, 0));

        // Set/clear collision on register 6: set wins.
        apply_stimulus(mk(1, 0, 0, 0, 0, 0, 6, 1, 1, 6), ex(0, 0, 0, 0));
        apply_stimulus(mk(1, 1, 6, 32'h5, 0, 0, 6, 1, 1, 6), ex(0, 32'h5, 0, 32'h40));
        apply_stimulus(mk(1, 0, 0, 0, 0, 0, 6, 1, 0, 0), ex(0, 32'h5, 1, 32'h40));

        // Port 2 hazard independent of a clean port 1.
        apply_stimulus(mk(1, 0, 0, 0, 2, 1, 6, 0, 1, 10), ex(0, 32'h5, 0, 32'h40));
        apply_stimulus(mk(1, 0, 0, 0, 2, 1, 10, 1, 0, 0), ex(0, 0, 1, 32'h440));
        apply_stimulus(mk(1, 0, 0, 0, 2, 1, 10, 0, 0, 0), ex(0, 0, 0, 32'h440));

        // pend_set to addr 0 ignored; write-back clears bit 6.
        apply_stimulus(mk(1, 1, 6, 32'h66, 6, 0, 0, 0, 1, 0), ex(32'h66, 0, 0, 32'h440));
        apply_stimulus(mk(1, 0, 0, 0, 6, 0, 0, 0, 0, 0), ex(32'h66, 0, 0, 32'h400));

        // Re-set an already pending register; plain write to a clean one.
        apply_stimulus(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 10), ex(0, 0, 0, 32'h400));
        apply_stimulus(mk(1, 1, 3, 32'h33, 0, 0, 0, 0, 0, 0), ex(0, 0, 0, 32'h400));
        apply_stimulus(mk(1, 0, 0, 0, 3, 0, 10, 1, 0, 0), ex(32'h33, 0, 1, 32'h400));

        // Mid-run reset discards data and pending state immediately.
        apply_stimulus(mk(1, 1, 5, 32'hDEAD_BEEF, 0, 0, 0, 0, 1, 7), ex(0, 0, 0, 32'h400));
        apply_stimulus(mk(1, 0, 0, 0, 5, 0, 7, 1, 0, 0), ex(32'hDEAD_BEEF, 0, 1, 32'h480));
        apply_stimulus(mk(0, 0, 0, 0, 5, 0, 7, 1, 0, 0), ex(0, 0, 0, 0));
        apply_stimulus(mk(0, 1, 5, 32'h1234, 5, 1, 7, 1, 1, 5), ex(0, 0, 0, 0));
        apply_stimulus(mk(1, 0, 0, 0, 5, 1, 10, 1, 0, 0), ex(0, 0, 0, 0));

        // Wait a bounded number of edges for the monitor to drain the queue.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(negedge clk);
        end
        #1;
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("[TB] FAIL drain: %0d vectors left unchecked, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
